quadram_dp: RTL and testbench
=============================

Name: quadram_dp

Overview:
Parametrised successor to the team's single-port byte-enable RAM. Adds configurable width and depth, a second read-only port (B) and a hardware zero-fill sequencer that runs after reset. Selectable read-first/write-first on port A. Used as scratch/vertex storage beside the subdivision datapath, where one engine writes while another reads.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8; NBYTES = DATA_WIDTH/8
A_WIDTH, 11, address width; NUM_WORDS = 2**A_WIDTH
READ_FIRST, 1, port A collision mode: 1 = a_dout returns pre-write data, 0 = returns post-write merged data
CLEAR_ON_RESET, 1, 1 = zero-fill all words after reset; 0 = no sweep, contents untouched by reset

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous active-high reset
busy  out  1  high while zero-fill sweep runs; port requests ignored
a_en  in  1  port A enable
a_we  in  NBYTES  port A byte write enables, bit i -> bits [8i+7:8i]
a_addr  in  A_WIDTH  port A address
a_din  in  DATA_WIDTH  port A write data
a_dout  out  DATA_WIDTH  port A read data, registered
b_en  in  1  port B (read-only) enable
b_addr  in  A_WIDTH  port B address
b_dout  out  DATA_WIDTH  port B read data, registered

Behaviour:
- Reset (rst=1 at posedge): a_dout=0, b_dout=0, clr_addr=0. With CLEAR_ON_RESET=1: state<=CLEAR, busy<=1. With CLEAR_ON_RESET=0: state<=IDLE, busy<=0. Reset has priority over everything.
- States: CLEAR, IDLE. CLEAR exists only when CLEAR_ON_RESET=1.
- CLEAR: each posedge with rst=0 writes 0 to RAM[clr_addr], then clr_addr+1. On the cycle that writes NUM_WORDS-1: state<=IDLE, busy<=0. busy is high for exactly NUM_WORDS cycles after rst falls.
- During CLEAR: a_en/b_en/a_we ignored, no writes from port A, a_dout=b_dout=0.
- rst during CLEAR restarts the sweep at address 0.
- IDLE, port A, a_en=1: read latency 1 (a_dout valid at the posedge after request). Each byte with a_we[i]=1 is written from a_din. Bytes not enabled are preserved.
- a_dout on a write: READ_FIRST=1 gives the old word. READ_FIRST=0 gives the merged word (new bytes where we=1, old bytes elsewhere).
- IDLE, port A, a_en=0: a_dout<=0, no write.
- IDLE, port B: b_en=1 gives b_dout<=RAM[b_addr], latency 1. b_en=0 gives b_dout<=0.
- Collision (same cycle, a_en & |a_we, b_en, a_addr==b_addr): b_dout always returns the pre-write word. The write completes and is visible to both ports next cycle.
- Back-to-back accesses on both ports are allowed every cycle. No stall other than busy.
- a_we with a_en=0 has no effect.

Optional Feature:
Macro QUADRAM_PARITY_EN.
- Defined:
  - Each stored byte carries one even-parity bit, updated on every byte write. CLEAR writes parity 0.
  - Extra outputs a_perr and b_perr, width NBYTES each. They are registered alongside the matching dout; bit i=1 when byte i's recomputed parity differs from the stored bit.
  - a_perr/b_perr=0 when the port is disabled, during CLEAR and at reset.
- Not defined: no parity storage, and the a_perr/b_perr ports do not exist.

Test Plan:
- Reset then clear: DATA_WIDTH=32, A_WIDTH=4, CLEAR_ON_RESET=1; pulse rst 1 cycle -> busy high exactly 16 cycles. Then read all 16 addresses on A and B -> all 0x00000000.
- Byte enables: write 0xDEADBEEF @5 with we=4'hF, then 0x11223344 @5 with we=4'b0101 -> B read @5 = 0xDE22BE44.
- Collision modes: RAM[3]=0xAAAAAAAA. Same cycle: A writes 0x55555555 we=F @3 while B reads @3.
  - READ_FIRST=1 -> a_dout=0xAAAAAAAA, b_dout=0xAAAAAAAA.
  - READ_FIRST=0 -> a_dout=0x55555555, b_dout=0xAAAAAAAA.
  - Next cycle B read @3 -> 0x55555555.
- Mid-clear reset: assert rst at clear cycle 7 -> sweep restarts at 0; busy stays high 16 cycles after the second rst falls. A write attempted during busy is not stored (reads 0).
- Disabled ports: a_en=b_en=0 after reading nonzero data -> a_dout=b_dout=0 next cycle.
- QUADRAM_PARITY_EN: write 0x000000FF, then flip stored bit 0 via hierarchical deposit, read on B -> b_dout=0x000000FE, b_perr=4'b0001. An unmodified word gives b_perr=0.

Source files
------------

// File: rtl/quadram_dp.sv
// quadram_dp: dual-port RAM (port A read/write with byte enables, port B
// read-only) with a zero-fill sweep after reset and selectable collision mode.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   busy                high while the zero-fill sweep runs
//   a_en, a_we, a_addr  port A enable, byte write enables, address
//   a_din, a_dout       port A write data, registered read data
//   b_en, b_addr        port B enable, address
//   b_dout              port B registered read data
//   a_perr, b_perr      per-byte parity error flags (QUADRAM_PARITY_EN only)
// Optional feature macro: QUADRAM_PARITY_EN adds per-byte even parity storage.
module quadram_dp #(
    parameter int DATA_WIDTH     = 32,
    parameter int A_WIDTH        = 11,
    parameter bit READ_FIRST     = 1'b1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    busy,
    input  logic                    a_en,
    input  logic [DATA_WIDTH/8-1:0] a_we,
    input  logic [A_WIDTH-1:0]      a_addr,
    input  logic [DATA_WIDTH-1:0]   a_din,
    output logic [DATA_WIDTH-1:0]   a_dout,
    input  logic                    b_en,
    input  logic [A_WIDTH-1:0]      b_addr,
    output logic [DATA_WIDTH-1:0]   b_dout
`ifdef QUADRAM_PARITY_EN
    ,
    output logic [DATA_WIDTH/8-1:0] a_perr,
    output logic [DATA_WIDTH/8-1:0] b_perr
`endif
);

    localparam int NBYTES    = DATA_WIDTH / 8;
    localparam int NUM_WORDS = 2 ** A_WIDTH;

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t                 state;
    logic [A_WIDTH-1:0]     clr_addr;
    logic [DATA_WIDTH-1:0]  mem [NUM_WORDS];
    logic [DATA_WIDTH-1:0]  a_old;
    logic [DATA_WIDTH-1:0]  a_merged;
    logic                   clr_wr;
    logic                   a_wr;

    // Reset wins over both the sweep write and port A writes.
    assign clr_wr = !rst && (state == CLEAR);
    assign a_wr   = !rst && (state == IDLE) && a_en;
    assign a_old  = mem[a_addr];

    always_comb begin
        a_merged = a_old;
        for (int i = 0; i < NBYTES; i++) begin
            if (a_we[i]) a_merged[8*i +: 8] = a_din[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (clr_wr) begin
            mem[clr_addr] <= '0;
        end else if (a_wr) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (a_we[i]) mem[a_addr][8*i +: 8] <= a_din[8*i +: 8];
            end
        end
    end

`ifdef QUADRAM_PARITY_EN
    logic [NBYTES-1:0] par [NUM_WORDS];
    logic [NBYTES-1:0] a_old_par;
    logic [NBYTES-1:0] a_merged_par;
    logic [NBYTES-1:0] a_perr_nxt;
    logic [NBYTES-1:0] b_perr_nxt;

    function automatic logic [NBYTES-1:0] byte_par(input logic [DATA_WIDTH-1:0] w);
        logic [NBYTES-1:0] p;
        for (int i = 0; i < NBYTES; i++) p[i] = ^w[8*i +: 8];
        return p;
    endfunction

    assign a_old_par = par[a_addr];

    always_comb begin
        a_merged_par = a_old_par;
        for (int i = 0; i < NBYTES; i++) begin
            if (a_we[i]) a_merged_par[i] = ^a_din[8*i +: 8];
        end
    end

    // Write-first view reports on the merged word, so freshly written bytes are clean.
    assign a_perr_nxt = READ_FIRST ? (byte_par(a_old) ^ a_old_par)
                                   : (byte_par(a_merged) ^ a_merged_par);
    assign b_perr_nxt = byte_par(mem[b_addr]) ^ par[b_addr];

    always_ff @(posedge clk) begin
        if (clr_wr) begin
            par[clr_addr] <= '0;
        end else if (a_wr) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (a_we[i]) par[a_addr][i] <= ^a_din[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state == CLEAR) begin
            a_perr <= '0;
            b_perr <= '0;
        end else begin
            a_perr <= a_en ? a_perr_nxt : '0;
            b_perr <= b_en ? b_perr_nxt : '0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR_ON_RESET ? CLEAR : IDLE;
            busy     <= CLEAR_ON_RESET;
            clr_addr <= '0;
            a_dout   <= '0;
            b_dout   <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    a_dout   <= '0;
                    b_dout   <= '0;
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == '1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    busy <= 1'b0;
                    if (a_en) a_dout <= READ_FIRST ? a_old : a_merged;
                    else      a_dout <= '0;
                    // Nonblocking read of mem gives the pre-write word on collision.
                    b_dout <= b_en ? mem[b_addr] : '0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quadram_dp.sv
// tb_quadram_dp: randomized and directed bench for quadram_dp, two instances
// (read-first and write-first) checked every cycle against a word-array model.
module tb_quadram_dp;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_en;
    logic [3:0]  a_we;
    logic [3:0]  a_addr;
    logic [31:0] a_din;
    logic        b_en;
    logic [3:0]  b_addr;
    logic        busy_rf, busy_wf;
    logic [31:0] a_dout_rf, a_dout_wf, b_dout_rf, b_dout_wf;
`ifdef QUADRAM_PARITY_EN
    logic [3:0]  a_perr_rf, a_perr_wf, b_perr_rf, b_perr_wf;
`endif

    always #5 clk = ~clk;

    quadram_dp #(.DATA_WIDTH(32), .A_WIDTH(4), .READ_FIRST(1'b1), .CLEAR_ON_RESET(1'b1)) u_rf (
        .clk(clk), .rst(rst), .busy(busy_rf),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout_rf),
        .b_en(b_en), .b_addr(b_addr), .b_dout(b_dout_rf)
`ifdef QUADRAM_PARITY_EN
        , .a_perr(a_perr_rf), .b_perr(b_perr_rf)
`endif
    );

    quadram_dp #(.DATA_WIDTH(32), .A_WIDTH(4), .READ_FIRST(1'b0), .CLEAR_ON_RESET(1'b1)) u_wf (
        .clk(clk), .rst(rst), .busy(busy_wf),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout_wf),
        .b_en(b_en), .b_addr(b_addr), .b_dout(b_dout_wf)
`ifdef QUADRAM_PARITY_EN
        , .a_perr(a_perr_wf), .b_perr(b_perr_wf)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: plain word array plus a count of sweep cycles left.
    logic [31:0] model [16];
    int          clr_left = 0;
    bit          chk = 1'b0;
    bit          hold = 1'b0;
    logic [31:0] exp_a_rf, exp_a_wf, exp_b;
    logic        exp_busy;

    always @(posedge clk) begin
        logic [31:0] old, merged;
        if (rst) begin
            exp_a_rf = '0; exp_a_wf = '0; exp_b = '0;
            exp_busy = 1'b1;
            clr_left = 16;
            chk = 1'b1;
        end else if (clr_left > 0) begin
            model[16 - clr_left] = '0;
            clr_left--;
            exp_busy = (clr_left != 0);
            exp_a_rf = '0; exp_a_wf = '0; exp_b = '0;
        end else begin
            old = model[a_addr];
            merged = old;
            for (int i = 0; i < 4; i++)
                if (a_we[i]) merged[8*i +: 8] = a_din[8*i +: 8];
            exp_b    = b_en ? model[b_addr] : '0;
            exp_a_rf = a_en ? old : '0;
            exp_a_wf = a_en ? merged : '0;
            if (a_en) model[a_addr] = merged;
            exp_busy = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk && !hold) begin
            check("busy_rf", {31'b0, busy_rf}, {31'b0, exp_busy});
            check("busy_wf", {31'b0, busy_wf}, {31'b0, exp_busy});
            check("a_dout_rf", a_dout_rf, exp_a_rf);
            check("a_dout_wf", a_dout_wf, exp_a_wf);
            check("b_dout_rf", b_dout_rf, exp_b);
            check("b_dout_wf", b_dout_wf, exp_b);
`ifdef QUADRAM_PARITY_EN
            check("perr_all", {16'b0, a_perr_rf, a_perr_wf, b_perr_rf, b_perr_wf}, 32'h0);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        a_en = 0; a_we = 0; b_en = 0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy_rf && n < 100) begin
            n++;
            step();
        end
    endtask

    int n;

    initial begin
        rst = 1; a_en = 0; a_we = 0; a_addr = 0; a_din = 0; b_en = 0; b_addr = 0;
        step();
        check("reset_a", a_dout_rf, 32'h0);
        check("reset_busy", {31'b0, busy_rf}, 32'h1);
        rst = 0;
        count_busy(n);
        check("busy_len", n, 16);

        for (int i = 0; i < 16; i++) begin
            a_en = 1; a_addr = 4'(i); b_en = 1; b_addr = 4'(15 - i);
            step();
            check("clear_a", a_dout_rf, 32'h0);
            check("clear_b", b_dout_rf, 32'h0);
        end

        // Byte enables.
        a_en = 1; b_en = 0; a_addr = 5; a_we = 4'hF; a_din = 32'hDEADBEEF; step();
        a_we = 4'b0101; a_din = 32'h11223344; step();
        a_en = 0; a_we = 0; b_en = 1; b_addr = 5; step();
        check("byte_en_b", b_dout_rf, 32'hDE22BE44);
        check("model_pin", model[5], 32'hDE22BE44);

        // Collision.
        a_en = 1; b_en = 0; a_addr = 3; a_we = 4'hF; a_din = 32'hAAAAAAAA; step();
        a_din = 32'h55555555; b_en = 1; b_addr = 3; step();
        check("coll_a_rf", a_dout_rf, 32'hAAAAAAAA);
        check("coll_a_wf", a_dout_wf, 32'h55555555);
        check("coll_b", b_dout_rf, 32'hAAAAAAAA);
        a_en = 0; a_we = 0; step();
        check("coll_after_b", b_dout_wf, 32'h55555555);

        // Disabled ports after nonzero reads.
        a_en = 1; a_addr = 3; b_en = 1; b_addr = 5; step();
        idle(); step();
        check("dis_a", a_dout_rf, 32'h0);
        check("dis_b", b_dout_rf, 32'h0);

        // Randomized traffic, with occasional resets.
        for (int c = 0; c < 600; c++) begin
            rst    = ($urandom_range(0, 199) == 0);
            a_en   = $urandom_range(0, 1);
            a_we   = 4'($urandom);
            a_addr = 4'($urandom);
            a_din  = $urandom;
            b_en   = $urandom_range(0, 1);
            b_addr = ($urandom_range(0, 3) == 0) ? a_addr : 4'($urandom);
            step();
        end
        rst = 0; idle();
        count_busy(n);

        // Mid-clear reset, with a write attempted while busy.
        rst = 1; step();
        rst = 0;
        repeat (7) step();
        rst = 1; step();
        rst = 0;
        a_en = 1; a_we = 4'hF; a_addr = 2; a_din = 32'hCAFEF00D;
        count_busy(n);
        check("busy_len_mid", n, 16);
        a_we = 0; a_addr = 2; step();
        check("busy_write_dropped", a_dout_rf, 32'h0);
        idle();

`ifdef QUADRAM_PARITY_EN
        a_en = 1; a_we = 4'hF; a_addr = 7; a_din = 32'h000000FF; step();
        a_addr = 8; a_din = 32'h12345678; step();
        idle(); step();
        hold = 1;
        u_rf.mem[7][0] = 1'b0;
        u_wf.mem[7][0] = 1'b0;
        b_en = 1; b_addr = 7; step();
        check("par_b_dout", b_dout_rf, 32'h000000FE);
        check("par_b_perr", {28'b0, b_perr_rf}, 32'h1);
        b_addr = 8; step();
        check("par_clean", {28'b0, b_perr_rf}, 32'h0);
        b_en = 0; a_en = 1; a_we = 4'hF; a_addr = 7; a_din = 32'h000000FF; step();
        idle(); step();
        hold = 0;
`endif

        repeat (2) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
